// File: rtl/jtflane_gfx_bus_pkg.sv
// Shared constants for the graphics board CPU window: region bases, register indices, control bits.
// Also holds the address decoder used by the bus logic.
package jtflane_gfx_bus_pkg;

    localparam logic [13:0] REG_BASE  = 14'h0000;
    localparam logic [13:0] WRAM_BASE = 14'h1000;
    localparam logic [13:0] VRAM_BASE = 14'h2000;

    localparam int REG_SCRX_LO = 0;
    localparam int REG_SCRX_HI = 1;
    localparam int REG_SCRY    = 2;
    localparam int REG_CTRL    = 7;

    localparam int CTRL_NMI_EN = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLIP   = 3;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_REG,
        SEL_WRAM,
        SEL_VRAM
    } sel_e;

    function automatic sel_e addr_decode(input logic [13:0] addr);
        sel_e sel;
        sel = SEL_NONE;
        if ((addr & 14'h2000) == VRAM_BASE)
            sel = SEL_VRAM;
        else if ((addr & 14'h3000) == WRAM_BASE)
            sel = SEL_WRAM;
        else if ((addr & 14'h3ff8) == REG_BASE)
            sel = SEL_REG;
        return sel;
    endfunction

endpackage

// File: rtl/jtflane_gfx_bus_irq.sv
// Vblank IRQ latch and one-line-every-32 NMI generator for the graphics board.
// Outputs are flops: they move on the clk after the triggering edge or control write.
module jtflane_gfx_bus_irq (
    input  logic       clk,
    input  logic       rst,
    input  logic       lvbl,
    input  logic [8:0] hdump,
    input  logic       ctrl_wr,
    input  logic       ctrl_irq_en,
    input  logic       ctrl_nmi_en,
    input  logic       irq_en,
    input  logic       nmi_en,
    output logic       gfx_irqn,
    output logic       gfx_nmin
);

    logic       lvbl_q, lvbl_d;
    logic       irq_q, irq_d;
    logic       nmi_q, nmi_d;
    logic [4:0] cnt_q, cnt_d;
    logic       lvbl_fall, lvbl_rise, line_start;

    assign lvbl_fall  = lvbl_q & ~lvbl;
    assign lvbl_rise  = ~lvbl_q & lvbl;
    assign line_start = (hdump == 9'd0);

    always_comb begin
        lvbl_d = lvbl;

        irq_d = irq_q;
        if (lvbl_rise)
            irq_d = 1'b0;
        if (lvbl_fall && irq_en)
            irq_d = 1'b1;
        // Clearing through R7 must beat a simultaneous vblank start
        if (ctrl_wr && !ctrl_irq_en)
            irq_d = 1'b0;

        cnt_d = cnt_q;
        if (line_start)
            cnt_d = cnt_q + 5'd1;
        if (lvbl_rise)
            cnt_d = 5'd0;

        nmi_d = nmi_q;
        if (line_start)
            nmi_d = (cnt_q == 5'd0);
        if (!nmi_en || (ctrl_wr && !ctrl_nmi_en))
            nmi_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        lvbl_q <= lvbl_d;
        if (rst) begin
            irq_q <= 1'b0;
            nmi_q <= 1'b0;
            cnt_q <= 5'd0;
        end else begin
            irq_q <= irq_d;
            nmi_q <= nmi_d;
            cnt_q <= cnt_d;
        end
    end

    assign gfx_irqn = ~irq_q;
    assign gfx_nmin = ~nmi_q;

endmodule

// File: rtl/jtframe_dual_ram.sv
// Two-port synchronous RAM on one clock, both ports read-first with 1-clk read latency.
// A same-clk write and read of one address returns the old word on the reading port.
module jtframe_dual_ram #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [DW-1:0] data0,
    input  logic [AW-1:0] addr0,
    input  logic          we0,
    output logic [DW-1:0] q0,
    input  logic [DW-1:0] data1,
    input  logic [AW-1:0] addr1,
    input  logic          we1,
    output logic [DW-1:0] q1
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        q0 <= mem[addr0];
        q1 <= mem[addr1];
        // Port 0 is written last so it wins a same-address collision
        if (we1)
            mem[addr1] <= data1;
        if (we0)
            mem[addr0] <= data0;
    end

endmodule

// File: rtl/jtframe_ram.sv
// Single-port synchronous RAM, read-first.
// Read data appears one clk after the address when cen is high.
module jtframe_ram #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          cen,
    input  logic [DW-1:0] data,
    input  logic [AW-1:0] addr,
    input  logic          we,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (cen) begin
            q <= mem[addr];
            if (we)
                mem[addr] <= data;
        end
    end

endmodule

// File: rtl/jtflane_gfx_bus.sv
// CPU window of the graphics board: control registers, work RAM, VRAM and interrupt lines.
// Reads return data one clk after a stable address; the video VRAM port has 1-clk latency.
module jtflane_gfx_bus
    import jtflane_gfx_bus_pkg::*;
#(
    parameter int VRAM_AW = 13
) (
    input  logic               rst,
    input  logic               clk,
    input  logic               cpu_cen,
    input  logic [13:0]        cpu_addr,
    input  logic               cpu_rnw,
    input  logic [7:0]         cpu_dout,
    input  logic               gfx_cs,
    output logic [7:0]         gfx_dout,
    output logic               gfx_irqn,
    output logic               gfx_nmin,
    input  logic [8:0]         vdump,
    input  logic [8:0]         hdump,
    input  logic               lvbl,
    input  logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_data,
    output logic [8:0]         scrx,
    output logic [7:0]         scry,
    output logic               flip
);

    sel_e       sel;
    sel_e       rd_sel_q, rd_sel_d;
    logic [7:0] rd_reg_q, rd_reg_d;
    logic [7:0] regs_q [8];
    logic [7:0] regs_d [8];
    logic       cpu_wr, ctrl_wr;
    logic [7:0] wram_q, vram_q, ctrl;
    logic       unused_vdump;

    assign sel     = addr_decode(cpu_addr);
    assign cpu_wr  = cpu_cen & gfx_cs & ~cpu_rnw;
    assign ctrl_wr = cpu_wr && (sel == SEL_REG) && (cpu_addr[2:0] == 3'(REG_CTRL));

    always_comb begin
        regs_d = regs_q;
        if (cpu_wr && sel == SEL_REG)
            regs_d[cpu_addr[2:0]] = cpu_dout;
        rd_sel_d = gfx_cs ? sel : SEL_NONE;
        rd_reg_d = regs_q[cpu_addr[2:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++)
                regs_q[i] <= 8'd0;
            rd_sel_q <= SEL_NONE;
            rd_reg_q <= 8'd0;
        end else begin
            regs_q   <= regs_d;
            rd_sel_q <= rd_sel_d;
            rd_reg_q <= rd_reg_d;
        end
    end

    // RAM outputs are already registered, so only flops feed this mux and all regions share one latency
    always_comb begin
        case (rd_sel_q)
            SEL_REG:  gfx_dout = rd_reg_q;
            SEL_WRAM: gfx_dout = wram_q;
            SEL_VRAM: gfx_dout = vram_q;
            default:  gfx_dout = 8'hff;
        endcase
    end

    assign ctrl = regs_q[REG_CTRL];
    assign scrx = {regs_q[REG_SCRX_HI][0], regs_q[REG_SCRX_LO]};
    assign scry = regs_q[REG_SCRY];
    assign flip = ctrl[CTRL_FLIP];

    jtframe_ram #(.DW(8), .AW(12)) u_wram (
        .clk  (clk),
        .cen  (1'b1),
        .data (cpu_dout),
        .addr (cpu_addr[11:0]),
        .we   (cpu_wr && sel == SEL_WRAM),
        .q    (wram_q)
    );

    jtframe_dual_ram #(.DW(8), .AW(VRAM_AW)) u_vram (
        .clk   (clk),
        .data0 (cpu_dout),
        .addr0 (cpu_addr[VRAM_AW-1:0]),
        .we0   (cpu_wr && sel == SEL_VRAM),
        .q0    (vram_q),
        .data1 (8'd0),
        .addr1 (vram_addr),
        .we1   (1'b0),
        .q1    (vram_data)
    );

    jtflane_gfx_bus_irq u_irq (
        .clk         (clk),
        .rst         (rst),
        .lvbl        (lvbl),
        .hdump       (hdump),
        .ctrl_wr     (ctrl_wr),
        .ctrl_irq_en (cpu_dout[CTRL_IRQ_EN]),
        .ctrl_nmi_en (cpu_dout[CTRL_NMI_EN]),
        .irq_en      (ctrl[CTRL_IRQ_EN]),
        .nmi_en      (ctrl[CTRL_NMI_EN]),
        .gfx_irqn    (gfx_irqn),
        .gfx_nmin    (gfx_nmin)
    );

    assign unused_vdump = ^vdump;

endmodule

// File: doc/jtflane_gfx_bus.md
JTFLANE_GFX_BUS -- requirements
Module: jtflane_gfx_bus

Interface
REQ-001 SHALL have parameter VRAM_AW, default 13, giving the VRAM address width (8 kB).
REQ-002 SHALL have ports rst (in, 1): reset, synchronous, active-high; clk (in, 1): clock, 24 MHz.
REQ-003 SHALL have cpu_cen (in, 1): CPU bus strobe, 3 MHz.
REQ-004 SHALL have cpu_addr (in, 14): CPU A[13:0].
REQ-005 SHALL have cpu_rnw (in, 1): 1 = read, 0 = write.
REQ-006 SHALL have cpu_dout (in, 8): CPU write data.
REQ-007 SHALL have gfx_cs (in, 1): active-high window select from the main board.
REQ-008 SHALL have gfx_dout (out, 8): read data to the CPU.
REQ-009 SHALL have gfx_irqn (out, 1): active-low vblank IRQ.
REQ-010 SHALL have gfx_nmin (out, 1): active-low periodic NMI.
REQ-011 SHALL have vdump (in, 9) and hdump (in, 9): video counters.
REQ-012 SHALL have lvbl (in, 1): active-low vertical blank.
REQ-013 SHALL have vram_addr (in, VRAM_AW) and vram_data (out, 8): video-side read port.
REQ-014 SHALL have scrx (out, 9), scry (out, 8) and flip (out, 1): scroll and flip registers.

Function
REQ-015 SHALL decode the window: 0x0000-0x0007 control registers R0-R7; 0x1000-0x1FFF 4 kB work RAM; 0x2000-0x3FFF VRAM; all else unmapped.
REQ-016 SHALL perform a write only when cpu_cen & gfx_cs & ~cpu_rnw: exactly one write per strobe, none while cpu_cen=0.
REQ-017 SHALL ignore writes to unmapped space, and unmapped reads SHALL return 0xFF.
REQ-018 SHALL register gfx_dout: valid on the clk following a stable address, with 1-clk latency for registers and RAMs alike, and updated every clk independent of cpu_cen.
REQ-019 SHALL hold gfx_dout at 0xFF when gfx_cs=0.
REQ-020 SHALL map the registers as: R0 = scrx[7:0]; R1 bit0 = scrx[8]; R2 = scry; R7 bit0 = nmi_en, bit1 = irq_en, bit3 = flip; R3-R6 are storage only.
REQ-021 SHALL return the full written byte on any register readback.
REQ-022 SHALL give the video port a 1-clk read latency, independent of CPU traffic; a same-clk CPU write to the same address SHALL yield either old or new data, never corruption.
REQ-023 SHALL set an IRQ latch on the falling edge of lvbl (detected against a 1-clk registered copy) when irq_en=1; gfx_irqn = ~latch.
REQ-024 SHALL clear the IRQ latch on a write to R7 with bit1=0, or on the rising edge of lvbl.
REQ-025 SHALL let an R7 clear win over a simultaneous lvbl falling edge in the same clk, so the latch stays clear.
REQ-026 SHALL keep an already-set IRQ latch set when a write to R7 keeps bit1=1.
REQ-027 SHALL form an NMI line counter, advanced at each hdump==0 clk, that wraps modulo 32 and resets to 0 at the lvbl rising edge.
REQ-028 SHALL drive gfx_nmin low when nmi_en=1 and the counter reaches 0 at hdump==0, held low until the next hdump==0 (one scanline).
REQ-029 SHALL force gfx_nmin high immediately when nmi_en is cleared mid-pulse.

Reset
REQ-030 SHALL, while rst=1, force R0-R7 to 0, scrx/scry/flip to 0, the IRQ latch clear, gfx_irqn=1, gfx_nmin=1, gfx_dout=0xFF and the NMI counter to 0.
REQ-031 SHALL leave RAM contents unchanged by reset.
REQ-032 SHALL, when rst is asserted mid-pulse, release IRQ/NMI on the next clk.

Structure
REQ-033 SHALL place the window base addresses, register indices and R7 bit positions in the shared core package.
REQ-034 SHALL instantiate jtframe_dual_ram once for VRAM: port 0 CPU, port 1 video.
REQ-035 SHALL implement the work RAM as a single-port jtframe_ram.

Verification
REQ-036 SHALL verify: write 0x5A to 0x2123, then read 0x2123 -> gfx_dout=0x5A 1 clk later; vram_addr=0x0123 -> vram_data=0x5A.
REQ-037 SHALL verify: write R0=0x34, R1=0x01, R7=0x08 -> scrx=0x134, flip=1; read 0x0000 -> 0x34.
REQ-038 SHALL verify: R7=0x02 then lvbl 1->0 -> gfx_irqn=0 next clk; write R7=0x00 -> gfx_irqn=1 next clk.
REQ-039 SHALL verify: R7=0x02 written in the same clk as lvbl falling -> gfx_irqn remains 1.
REQ-040 SHALL verify: R7=0x01 over one frame -> gfx_nmin low for exactly one scanline every 32 lines; clearing R7 mid-pulse -> gfx_nmin=1 next clk.
REQ-041 SHALL verify: read 0x0500 -> 0xFF; a write with gfx_cs=1 but cpu_cen=0 -> no change.
